// File: rtl/switch_pkg.sv
// Shared constants and types for the slide-switch input conditioner.
package switch_pkg;

    localparam int unsigned NSW_DEFAULT     = 4;
    localparam int unsigned DEB_CNT_DEFAULT = 100000;
    localparam int unsigned DEB_CNT_SIM     = 4;

    // Event index width; a single switch still needs one index bit.
    function automatic int unsigned idx_width(input int unsigned nsw);
        return (nsw > 1) ? int'($clog2(nsw)) : 1;
    endfunction

    localparam int unsigned IW_DEFAULT = idx_width(NSW_DEFAULT);

    typedef logic [IW_DEFAULT-1:0] idx_t;

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: 2-flop synchronizer, stability counter, debounced level
// and registered rise/fall pulses.
module sw_debounce_ch
    import switch_pkg::*;
#(
    parameter int unsigned DEB_CNT = DEB_CNT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw_i,
    output logic state_o,
    output logic rise_o,
    output logic fall_o,
    output logic flip_c
);

    localparam int unsigned CW = $clog2(DEB_CNT);

    logic          s1_q;
    logic          s2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          state_q;
    logic          state_d;
    logic          rise_q;
    logic          rise_d;
    logic          fall_q;
    logic          fall_d;

    // Counter only advances while the synchronized level disagrees with the
    // accepted level, and stops at DEB_CNT-1, so it can never wrap.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        flip_c  = 1'b0;
        if (s2_q == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CNT - 1)) begin
            state_d = s2_q;
            cnt_d   = '0;
            flip_c  = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        rise_d = flip_c & s2_q;
        fall_d = flip_c & ~s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= sw_raw_i;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign state_o = state_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// Slide-switch bank conditioner: per-channel debounce plus a serialized
// valid/ready stream of switch-change events (lowest index first).
module switch_debounce
    import switch_pkg::*;
#(
    parameter  int unsigned NSW     = NSW_DEFAULT,
    parameter  int unsigned DEB_CNT = DEB_CNT_DEFAULT,
    localparam int unsigned IW      = idx_width(NSW)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NSW-1:0] prswi,
    output logic [NSW-1:0] sw_state,
    output logic [NSW-1:0] sw_rise,
    output logic [NSW-1:0] sw_fall,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [IW-1:0]  evt_sw,
    output logic           evt_level,
    output logic           evt_overrun,
    input  logic           ovr_clr
);

    logic [NSW-1:0] flip_w;

    for (genvar g = 0; g < int'(NSW); g++) begin : g_ch
        sw_debounce_ch #(
            .DEB_CNT (DEB_CNT)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .sw_raw_i (prswi[g]),
            .state_o  (sw_state[g]),
            .rise_o   (sw_rise[g]),
            .fall_o   (sw_fall[g]),
            .flip_c   (flip_w[g])
        );
    end

    logic [NSW-1:0] pend_q;
    logic [NSW-1:0] pend_d;
    logic           evt_valid_q;
    logic           evt_valid_d;
    logic [IW-1:0]  evt_sw_q;
    logic [IW-1:0]  evt_sw_d;
    logic           evt_level_q;
    logic           evt_level_d;
    logic           ovr_q;
    logic           ovr_d;

    logic           load_c;
    logic           pick_found_c;
    logic [IW-1:0]  pick_idx_c;
    logic           pick_lvl_c;
    logic [NSW-1:0] pick_mask_c;
    logic [NSW-1:0] clr_mask_c;
    logic           ovr_set_c;

    // Lowest-index pending channel.
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        pick_lvl_c   = 1'b0;
        pick_mask_c  = '0;
        for (int i = 0; i < int'(NSW); i++) begin
            if (pend_q[i] && !pick_found_c) begin
                pick_found_c   = 1'b1;
                pick_idx_c     = IW'(i);
                pick_lvl_c     = sw_state[i];
                pick_mask_c[i] = 1'b1;
            end
        end
    end

    // Event register load, pend update and sticky overrun. A flip on the
    // edge its pend bit is consumed re-arms the pend and is not an overrun.
    always_comb begin
        load_c      = !evt_valid_q || evt_ready;
        clr_mask_c  = '0;
        evt_valid_d = evt_valid_q;
        evt_sw_d    = evt_sw_q;
        evt_level_d = evt_level_q;
        if (load_c) begin
            if (pick_found_c) begin
                evt_valid_d = 1'b1;
                evt_sw_d    = pick_idx_c;
                evt_level_d = pick_lvl_c;
                clr_mask_c  = pick_mask_c;
            end else begin
                evt_valid_d = 1'b0;
            end
        end
        pend_d    = (pend_q & ~clr_mask_c) | flip_w;
        ovr_set_c = |(flip_w & pend_q & ~clr_mask_c);
        if (ovr_set_c) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_sw_q    <= '0;
            evt_level_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            evt_valid_q <= evt_valid_d;
            evt_sw_q    <= evt_sw_d;
            evt_level_q <= evt_level_d;
            ovr_q       <= ovr_d;
        end
    end

    assign evt_valid   = evt_valid_q;
    assign evt_sw      = evt_sw_q;
    assign evt_level   = evt_level_q;
    assign evt_overrun = ovr_q;

endmodule
